axistream_egress_fifo: RTL

Store-and-forward packet FIFO directly downstream of the packet filter's AXI Stream forwarder. It accepts the forwarder's output stream (`fwd_*`) and buffers each packet in full before presenting it on the outgoing link, so a slow link stalls only this buffer and not the filter. A packet larger than the buffer is discarded and counted. The block also maintains forwarded and dropped packet counters for the register map.

---
 rtl/axistream_egress_fifo.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/axistream_egress_fifo.sv
// Store-and-forward egress packet FIFO. Whole packets are buffered before any
// beat is offered downstream; packets longer than the buffer are discarded and
// counted. Readout uses a registered RAM read feeding a two-entry output stage
// so the link can be served at one beat per cycle.
module axistream_egress_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [DATA_WIDTH-1:0] in_TDATA,
    input  logic                  in_TVALID,
    input  logic                  in_TLAST,
    output logic                  in_TREADY,
    output logic [DATA_WIDTH-1:0] out_TDATA,
    output logic                  out_TVALID,
    output logic                  out_TLAST,
    input  logic                  out_TREADY,
    output logic [31:0]           pkts_fwd,
    output logic [15:0]           pkts_dropped
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int MW    = DATA_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [PW-1:0] ONE_P   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } wr_state_t;

    wr_state_t state_reg, state_next;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] commit_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] used;
    logic [PW-1:0] partial;
    logic          full;

    // Goes high on the first edge after reset release; gates in_TREADY.
    logic          live_reg;

    // Packet storage; bit DATA_WIDTH carries TLAST.
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] rdata_reg;
    logic          rd_pend_reg;

    // Output stage: head register drives the port, skid catches the beat
    // already in flight from the RAM when the sink stalls.
    logic [DATA_WIDTH-1:0] out_data_reg;
    logic                  out_last_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] skid_data_reg;
    logic                  skid_last_reg;
    logic                  skid_valid_reg;

    logic [31:0] pkts_fwd_reg;
    logic [15:0] pkts_dropped_reg;

    logic       wr_en;
    logic       commit_en;
    logic       drop_enter;
    logic       drop_done;
    logic       pop;
    logic       rd_avail;
    logic       rd_en;
    logic [1:0] occ;
    logic [1:0] occ_limit;

    assign used     = wr_ptr_reg - rd_ptr_reg;
    assign partial  = wr_ptr_reg - commit_ptr_reg;
    assign full     = (used == DEPTH_P);

    assign pop      = out_valid_reg & out_TREADY;
    assign rd_avail = (rd_ptr_reg != commit_ptr_reg);
    // Beats held or in flight toward the output stage; it never exceeds two,
    // so a read is issued only when a slot will be free when the data lands.
    assign occ       = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg} + {1'b0, rd_pend_reg};
    assign occ_limit = pop ? 2'd3 : 2'd2;
    assign rd_en     = rd_avail & (occ < occ_limit);

    assign out_TDATA    = out_data_reg;
    assign out_TLAST    = out_last_reg;
    assign out_TVALID   = out_valid_reg;
    assign pkts_fwd     = pkts_fwd_reg;
    assign pkts_dropped = pkts_dropped_reg;

    // Write FSM next state, input ready and write/commit/drop decisions.
    always_comb begin
        state_next = state_reg;
        in_TREADY  = 1'b0;
        wr_en      = 1'b0;
        commit_en  = 1'b0;
        drop_enter = 1'b0;
        drop_done  = 1'b0;
        if (live_reg) begin
            case (state_reg)
                ST_ACCEPT: begin
                    // A whole buffer of one unfinished packet plus another
                    // beat means the packet can never fit: abandon it.
                    if ((partial == DEPTH_P) && in_TVALID) begin
                        drop_enter = 1'b1;
                        state_next = ST_DROP;
                    end else begin
                        in_TREADY = !full;
                        if (in_TVALID && !full) begin
                            wr_en     = 1'b1;
                            commit_en = in_TLAST;
                        end
                    end
                end
                ST_DROP: begin
                    in_TREADY = 1'b1;
                    if (in_TVALID && in_TLAST) begin
                        drop_done  = 1'b1;
                        state_next = ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    // FSM state, pointers and read-pipeline valid.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_reg      <= ST_ACCEPT;
            live_reg       <= 1'b0;
            wr_ptr_reg     <= '0;
            commit_ptr_reg <= '0;
            rd_ptr_reg     <= '0;
            rd_pend_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            live_reg  <= 1'b1;
            if (drop_enter) begin
                wr_ptr_reg <= commit_ptr_reg;
            end else if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_P;
            end
            if (commit_en) begin
                commit_ptr_reg <= wr_ptr_reg + ONE_P;
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + ONE_P;
            end
            rd_pend_reg <= rd_en;
        end
    end

    // Dual-port RAM with registered read; left unreset so it maps to block RAM.
    always_ff @(posedge axi_aclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg[ADDR_WIDTH-1:0]] <= {in_TLAST, in_TDATA};
        end
        if (rd_en) begin
            rdata_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    // Two-entry output stage: head holds steady under stall, skid absorbs.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (pop) begin
            if (skid_valid_reg) begin
                out_data_reg <= skid_data_reg;
                out_last_reg <= skid_last_reg;
                if (rd_pend_reg) begin
                    skid_data_reg <= rdata_reg[DATA_WIDTH-1:0];
                    skid_last_reg <= rdata_reg[DATA_WIDTH];
                end else begin
                    skid_valid_reg <= 1'b0;
                end
            end else if (rd_pend_reg) begin
                out_data_reg <= rdata_reg[DATA_WIDTH-1:0];
                out_last_reg <= rdata_reg[DATA_WIDTH];
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (rd_pend_reg) begin
            if (!out_valid_reg) begin
                out_data_reg  <= rdata_reg[DATA_WIDTH-1:0];
                out_last_reg  <= rdata_reg[DATA_WIDTH];
                out_valid_reg <= 1'b1;
            end else begin
                skid_data_reg  <= rdata_reg[DATA_WIDTH-1:0];
                skid_last_reg  <= rdata_reg[DATA_WIDTH];
                skid_valid_reg <= 1'b1;
            end
        end
    end

    // Forwarded counter wraps; dropped counter saturates.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            pkts_fwd_reg     <= '0;
            pkts_dropped_reg <= '0;
        end else begin
            if (pop && out_last_reg) begin
                pkts_fwd_reg <= pkts_fwd_reg + 32'd1;
            end
            if (drop_done && (pkts_dropped_reg != 16'hFFFF)) begin
                pkts_dropped_reg <= pkts_dropped_reg + 16'd1;
            end
        end
    end

endmodule
